// File: rtl/lsu_axi_master_pkg.sv
// Shared types and constants for the LSU-to-AXI-lite master.
package lsu_axi_master_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int RESP_W = 2;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_EXOKAY = 2'b01;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
  localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4,
    DONE    = 3'd5
  } state_t;

  // Anything other than OKAY, including EXOKAY, is reported as an error.
  function automatic logic resp_is_err(input logic [RESP_W-1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/lsu_axi_master.sv
// Single-outstanding core load/store port bridged onto an AXI-lite master.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for a core request; only state with req_ready=1
// RD_ADDR | presenting araddr with arvalid until arready
// RD_DATA | rready high, waiting for rvalid
// WR_REQ  | AW and W presented together, each retires on its own
// WR_RESP | bready high, waiting for bvalid
// DONE    | one-cycle resp_valid, then back to IDLE
module lsu_axi_master
  import lsu_axi_master_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [RESP_W-1:0] rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [STRB_W-1:0] wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [RESP_W-1:0] bresp,
  input  logic              bvalid,
  output logic              bready
);

  state_t            state;
  logic              aw_done;
  logic              w_done;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= req_we ? WR_REQ : RD_ADDR;
          end
        end
        RD_ADDR: begin
          if (arready) state <= RD_DATA;
        end
        RD_DATA: begin
          if (rvalid) begin
            resp_rdata <= rdata;
            resp_err   <= resp_is_err(rresp);
            state      <= DONE;
          end
        end
        WR_REQ: begin
          if (awready) aw_done <= 1'b1;
          if (wready)  w_done  <= 1'b1;
          // Both channels may complete in the same cycle, so look at the
          // live handshakes as well as the sticky flags.
          if ((aw_done || awready) && (w_done || wready)) state <= WR_RESP;
        end
        WR_RESP: begin
          if (bvalid) begin
            resp_err <= resp_is_err(bresp);
            state    <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state == IDLE);
  assign arvalid    = (state == RD_ADDR);
  assign rready     = (state == RD_DATA);
  assign awvalid    = (state == WR_REQ) && !aw_done;
  assign wvalid     = (state == WR_REQ) && !w_done;
  assign bready     = (state == WR_RESP);
  assign resp_valid = (state == DONE);

  assign araddr = addr_q;
  assign awaddr = addr_q;
  assign wdata  = wdata_q;
  assign wstrb  = wstrb_q;

endmodule
